// File: rtl/tt_uart_tx_top_if.sv
// ---------------------------------------------------------------------------
// tt_uart_tx_top_if
// This interface carries the TinyTapeout-style 8-bit pin buses of the UART
// transmitter.
//   io_in[0]    clk
//   io_in[1]    synchronous active-high reset
//   io_in[2]    write strobe (acts on its rising edge)
//   io_in[3]    nibble select (0 = low nibble, 1 = high nibble + commit)
//   io_in[7:4]  data nibble
//   io_out[0]   tx serial line, idle high
//   io_out[1]   busy
//   io_out[2]   fifo_full
//   io_out[3]   fifo_empty
//   io_out[6:4] FIFO count
//   io_out[7]   overflow (sticky)
// The master modport drives io_in. The slave modport is the design side.
// ---------------------------------------------------------------------------
interface tt_uart_tx_top_if;
   logic [7:0] io_in;
   logic [7:0] io_out;

   modport master (output io_in, input io_out);
   modport slave  (input io_in, output io_out);
endinterface

// File: rtl/tt_uart_tx_top.sv
// ---------------------------------------------------------------------------
// tt_uart_tx_top
// This is an 8N1 UART transmitter. Each byte is built from two nibble writes
// and placed in a 4-entry FIFO. A baud-timed FSM then shifts the byte out,
// LSB first.
// Parameter:
//   CLKS_PER_BIT  clock cycles per UART bit, 1..255
// Port:
//   bus  tt_uart_tx_top_if.slave; clk and reset arrive on io_in[1:0], and
//        the bit map is given in the interface file.
// ---------------------------------------------------------------------------
module tt_uart_tx_top #(
   parameter int CLKS_PER_BIT = 1
) (
   tt_uart_tx_top_if.slave bus
);
   localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic       clk;
   logic       srst;
   logic       wr;
   logic       sel;
   logic [3:0] nib;

   assign clk  = bus.io_in[0];
   assign srst = bus.io_in[1];
   assign wr   = bus.io_in[2];
   assign sel  = bus.io_in[3];
   assign nib  = bus.io_in[7:4];

   logic       wr_q_reg;
   logic [3:0] lo_nib_reg;
   logic [7:0] fifo_mem [4];
   logic [1:0] wptr_reg;
   logic [1:0] rptr_reg;
   logic [2:0] count_reg;
   logic       overflow_reg;

   state_t     state_reg, state_next;
   logic [7:0] bcnt_reg, bcnt_next;
   logic [2:0] bidx_reg, bidx_next;
   logic [7:0] shreg_reg, shreg_next;
   logic       tx_reg, tx_next;

   logic wr_evt;
   logic push_req;
   logic push_ok;
   logic pop;
   logic bit_end;

   assign wr_evt   = wr & ~wr_q_reg;
   assign push_req = wr_evt & sel;
   // IDLE pops as soon as a byte is present. The pop happens at the same edge that enters START.
   assign pop      = (state_reg == S_IDLE) && (count_reg != 3'd0);
   // When the FIFO is full, a push is still accepted if a pop happens at the same edge.
   assign push_ok  = push_req && ((count_reg != 3'd4) || pop);
   assign bit_end  = (bcnt_reg == BAUD_LAST);

   // FIFO storage has no reset. The pointers and the count define what is valid.
   always_ff @(posedge clk) begin
      if (!srst && push_ok) begin
         fifo_mem[wptr_reg] <= {nib, lo_nib_reg};
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_q_reg     <= 1'b0;
         lo_nib_reg   <= 4'd0;
         wptr_reg     <= 2'd0;
         rptr_reg     <= 2'd0;
         count_reg    <= 3'd0;
         overflow_reg <= 1'b0;
      end else begin
         wr_q_reg <= wr;
         if (wr_evt && !sel) begin
            lo_nib_reg <= nib;
         end
         if (push_ok) begin
            wptr_reg <= wptr_reg + 2'd1;
         end
         if (pop) begin
            rptr_reg <= rptr_reg + 2'd1;
         end
         if (push_ok && !pop) begin
            count_reg <= count_reg + 3'd1;
         end else if (pop && !push_ok) begin
            count_reg <= count_reg - 3'd1;
         end
         if (push_req && !push_ok) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg <= S_IDLE;
         bcnt_reg  <= 8'd0;
         bidx_reg  <= 3'd0;
         shreg_reg <= 8'd0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         bcnt_reg  <= bcnt_next;
         bidx_reg  <= bidx_next;
         shreg_reg <= shreg_next;
         tx_reg    <= tx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      bcnt_next  = bcnt_reg;
      bidx_next  = bidx_reg;
      shreg_next = shreg_reg;
      tx_next    = 1'b1;

      case (state_reg)
         S_IDLE: begin
            if (pop) begin
               shreg_next = fifo_mem[rptr_reg];
               bcnt_next  = 8'd0;
               state_next = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               bcnt_next  = 8'd0;
               bidx_next  = 3'd0;
               state_next = S_DATA;
            end else begin
               bcnt_next = bcnt_reg + 8'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               bcnt_next = 8'd0;
               if (bidx_reg == 3'd7) begin
                  state_next = S_STOP;
               end else begin
                  shreg_next = {1'b0, shreg_reg[7:1]};
                  bidx_next  = bidx_reg + 3'd1;
               end
            end else begin
               bcnt_next = bcnt_reg + 8'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               bcnt_next  = 8'd0;
               state_next = S_IDLE;
            end else begin
               bcnt_next = bcnt_reg + 8'd1;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // tx is computed from the next state. This keeps the registered line aligned with the state it represents.
      case (state_next)
         S_START: tx_next = 1'b0;
         S_DATA:  tx_next = shreg_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   assign bus.io_out = {overflow_reg,
                        count_reg,
                        (count_reg == 3'd0),
                        (count_reg == 3'd4),
                        (state_reg != S_IDLE),
                        tx_reg};
endmodule

// File: tb/tb_tt_uart_tx_top.sv
module tb_tt_uart_tx_top;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr  = 1'b0;
   logic       sel = 1'b0;
   logic [3:0] nib = 4'd0;

   always #5 clk = ~clk;

   tt_uart_tx_top_if bus1 ();
   tt_uart_tx_top_if bus4 ();
   assign bus1.io_in = {nib, sel, wr, rst, clk};
   assign bus4.io_in = {nib, sel, wr, rst, clk};

   tt_uart_tx_top #(.CLKS_PER_BIT(1)) dut1 (.bus(bus1));
   tt_uart_tx_top #(.CLKS_PER_BIT(4)) dut4 (.bus(bus4));

   typedef struct {
      logic       rst;
      logic       wr;
      logic       sel;
      logic [3:0] nib;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   logic log_en = 1'b0;
   logic tx_log[$];

   always @(negedge clk) begin
      if (log_en) tx_log.push_back(bus4.io_out[0]);
   end

   task automatic add_vec(input logic r, input logic w, input logic s,
                          input logic [3:0] n, input logic [7:0] e);
      vec_t v;
      v.rst = r; v.wr = w; v.sel = s; v.nib = n; v.exp = e;
      vecs.push_back(v);
   endtask

   // Inputs change on the falling edge. Outputs are read on the next falling edge.
   task automatic step(input logic r, input logic w, input logic s, input logic [3:0] n);
      rst = r; wr = w; sel = s; nib = n;
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end else begin
         $display("[TB] ok %s = 0x%0h", name, act);
      end
   endtask

   logic [7:0] exp_bytes [5];
   logic [7:0] rx_byte;
   int nf, prev_start, idx, waited;

   initial begin
      exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      // ---------------- table: CLKS_PER_BIT = 1 ----------------
      // reset
      add_vec(1,0,0,4'h0,8'h09); add_vec(1,0,0,4'h0,8'h09);
      // single byte 0xA5
      add_vec(0,1,0,4'h5,8'h09); add_vec(0,0,0,4'h0,8'h09);
      add_vec(0,1,1,4'hA,8'h11); add_vec(0,0,0,4'h0,8'h0A);
      add_vec(0,0,0,4'h0,8'h0B); add_vec(0,0,0,4'h0,8'h0A);
      add_vec(0,0,0,4'h0,8'h0B); add_vec(0,0,0,4'h0,8'h0A);
      add_vec(0,0,0,4'h0,8'h0A); add_vec(0,0,0,4'h0,8'h0B);
      add_vec(0,0,0,4'h0,8'h0A); add_vec(0,0,0,4'h0,8'h0B);
      add_vec(0,0,0,4'h0,8'h0B); add_vec(0,0,0,4'h0,8'h09);
      // strobe held high 5 cycles, byte 0x35, only one push
      add_vec(0,1,1,4'h3,8'h11); add_vec(0,1,1,4'h3,8'h0A);
      add_vec(0,1,1,4'h3,8'h0B); add_vec(0,1,1,4'h3,8'h0A);
      add_vec(0,1,1,4'h3,8'h0B); add_vec(0,0,0,4'h0,8'h0A);
      add_vec(0,0,0,4'h0,8'h0B); add_vec(0,0,0,4'h0,8'h0B);
      add_vec(0,0,0,4'h0,8'h0A); add_vec(0,0,0,4'h0,8'h0A);
      add_vec(0,0,0,4'h0,8'h0B); add_vec(0,0,0,4'h0,8'h09);
      // frame 0xF1 plus a queued copy, reset during DATA bit 3
      add_vec(0,1,0,4'h1,8'h09); add_vec(0,0,0,4'h0,8'h09);
      add_vec(0,1,1,4'hF,8'h11); add_vec(0,0,0,4'h0,8'h0A);
      add_vec(0,1,1,4'hF,8'h13); add_vec(0,0,0,4'h0,8'h12);
      add_vec(0,0,0,4'h0,8'h12); add_vec(0,0,0,4'h0,8'h12);
      add_vec(1,0,0,4'h0,8'h09);
      // clean 0x3C afterwards
      add_vec(0,1,0,4'hC,8'h09); add_vec(0,0,0,4'h0,8'h09);
      add_vec(0,1,1,4'h3,8'h11); add_vec(0,0,0,4'h0,8'h0A);
      add_vec(0,0,0,4'h0,8'h0A); add_vec(0,0,0,4'h0,8'h0A);
      add_vec(0,0,0,4'h0,8'h0B); add_vec(0,0,0,4'h0,8'h0B);
      add_vec(0,0,0,4'h0,8'h0B); add_vec(0,0,0,4'h0,8'h0B);
      add_vec(0,0,0,4'h0,8'h0A); add_vec(0,0,0,4'h0,8'h0A);
      add_vec(0,0,0,4'h0,8'h0B); add_vec(0,0,0,4'h0,8'h09);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].sel, vecs[i].nib);
         check($sformatf("vec%0d", i), {24'd0, bus1.io_out}, {24'd0, vecs[i].exp});
      end

      // ---------------- overflow, CLKS_PER_BIT = 4 ----------------
      step(1,0,0,4'h0); step(1,0,0,4'h0);
      check("rst4", {24'd0, bus4.io_out}, 32'h09);
      log_en = 1'b1;
      for (int b = 0; b < 6; b++) begin
         step(0,1,0,4'(b+1)); step(0,0,0,4'h0);
         step(0,1,1,4'(b+1));
         if (b == 4) begin
            check("ovf_full_after5", {31'd0, bus4.io_out[2]}, 32'd1);
            check("ovf_flag_after5", {31'd0, bus4.io_out[7]}, 32'd0);
         end
         if (b == 5) begin
            check("ovf_flag_after6", {31'd0, bus4.io_out[7]}, 32'd1);
            check("ovf_full_after6", {31'd0, bus4.io_out[2]}, 32'd1);
            check("ovf_count_after6", {29'd0, bus4.io_out[6:4]}, 32'd4);
         end
         step(0,0,0,4'h0);
      end
      repeat (230) step(0,0,0,4'h0);
      log_en = 1'b0;
      check("ovf_final_status", {24'd0, bus4.io_out}, 32'h89);

      nf = 0; prev_start = -1; idx = 1;
      while (idx + 39 < tx_log.size()) begin
         if (tx_log[idx] == 1'b0 && tx_log[idx-1] == 1'b1) begin
            for (int j = 0; j < 8; j++) rx_byte[j] = tx_log[idx + 4*(j+1) + 2];
            if (nf < 5) check($sformatf("ovf_byte%0d", nf), {24'd0, rx_byte}, {24'd0, exp_bytes[nf]});
            check($sformatf("ovf_stop%0d", nf), {31'd0, tx_log[idx+38]}, 32'd1);
            if (prev_start >= 0)
               check($sformatf("ovf_period%0d", nf), 32'(idx - prev_start), 32'd41);
            prev_start = idx;
            nf++;
            idx += 40;
         end else begin
            idx++;
         end
      end
      check("ovf_frame_count", 32'(nf), 32'd5);

      // ---------------- simultaneous push/pop, CLKS_PER_BIT = 4 ----------------
      step(1,0,0,4'h0); step(1,0,0,4'h0);
      for (int b = 0; b < 5; b++) begin
         step(0,1,0,4'h7); step(0,0,0,4'h0);
         step(0,1,1,4'h7); step(0,0,0,4'h0);
      end
      check("sim_count_full", {29'd0, bus4.io_out[6:4]}, 32'd4);
      step(0,1,0,4'h9); step(0,0,0,4'h0);
      waited = 0;
      while (bus4.io_out[1] !== 1'b0 && waited < 100) begin
         step(0,0,0,4'h0);
         waited++;
      end
      check("sim_wait_idle", {31'd0, bus4.io_out[1]}, 32'd0);
      // The FIFO is full and the FSM is in IDLE, so the next edge pops. A push is placed on that same edge.
      step(0,1,1,4'h9);
      check("sim_count", {29'd0, bus4.io_out[6:4]}, 32'd4);
      check("sim_full", {31'd0, bus4.io_out[2]}, 32'd1);
      check("sim_ovf", {31'd0, bus4.io_out[7]}, 32'd0);
      check("sim_busy", {31'd0, bus4.io_out[1]}, 32'd1);
      step(0,0,0,4'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
